// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and issues one outstanding imem request.
// IF/ID register plus a one-entry skid buffer absorb decode stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_pc_sel,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_branch_target,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc_plus4,
    output logic [31:0] o_if_instr
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        redirect;
    logic [31:0] target;
    logic        accept;
    logic        deliver;
    logic        consume;
    logic        ifid_free;
    logic        alu_lsb_unused;

    assign alu_lsb_unused = i_alu_result[0];

    assign redirect = i_pc_sel[0];
    assign target   = i_pc_sel[1] ? i_branch_target
                                  : {i_alu_result[31:1], 1'b0};

    // A full skid means IF/ID is also full, so no room for another word.
    assign o_imem_req = ~i_rst & (state == FETCH)
                      & ~redirect & ~skid_valid;
    assign o_imem_addr = pc;

    assign accept    = o_imem_req & i_imem_ready;
    assign deliver   = (state == WAIT) & i_imem_rvalid;
    assign consume   = o_if_valid & ~i_stall;
    assign ifid_free = ~o_if_valid | consume;

    assign o_if_pc_plus4 = o_if_pc + 32'd4;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= FETCH;
            pc         <= RESET_ADDR;
            req_pc     <= 32'd0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'd0;
            skid_instr <= 32'd0;
            o_if_valid <= 1'b0;
            o_if_pc    <= 32'd0;
            o_if_instr <= 32'd0;
        end else if (redirect) begin
            pc         <= target;
            o_if_valid <= 1'b0;
            skid_valid <= 1'b0;
            unique case (state)
                WAIT:    state <= i_imem_rvalid ? FETCH : DROP;
                DROP:    state <= i_imem_rvalid ? FETCH : DROP;
                default: state <= FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (accept) begin
                        pc     <= pc + 32'd4;
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT:    if (i_imem_rvalid) state <= FETCH;
                DROP:    if (i_imem_rvalid) state <= FETCH;
                default: state <= FETCH;
            endcase

            if (ifid_free) begin
                if (skid_valid) begin
                    o_if_valid <= 1'b1;
                    o_if_pc    <= skid_pc;
                    o_if_instr <= skid_instr;
                    skid_valid <= 1'b0;
                end else if (deliver) begin
                    o_if_valid <= 1'b1;
                    o_if_pc    <= req_pc;
                    o_if_instr <= i_imem_rdata;
                end else begin
                    o_if_valid <= 1'b0;
                end
            end else if (deliver) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc;
                skid_instr <= i_imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed corner sequences and a
// random run scored against an in-order fetch/flush reference model.
module tb_fetch_stage;

    localparam logic [31:0] RA = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_sel;
    logic [31:0] alu;
    logic [31:0] bt;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;

    fetch_stage #(.RESET_ADDR(RA)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pc_sel        (pc_sel),
        .i_alu_result    (alu),
        .i_branch_target (bt),
        .i_stall         (stall),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ready    (ready),
        .i_imem_rvalid   (rvalid),
        .i_imem_rdata    (rdata),
        .o_if_valid      (if_valid),
        .o_if_pc         (if_pc),
        .o_if_pc_plus4   (if_pc4),
        .o_if_instr      (if_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory responder state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat;

    // reference model: addresses fetched since the last flush, in order
    logic [31:0] exp_q[$];
    logic [31:0] nxt_pc;
    bit          hold_v;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    bit          s_acc;
    bit          s_rv;
    logic [31:0] s_addr;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        nxt_pc = RA;
        hold_v = 1'b0;
    endtask

    task automatic model_check();
        bit          redir;
        logic [31:0] tgt;
        logic [31:0] e;
        if (rst) return;
        redir = pc_sel[0];
        tgt   = pc_sel[1] ? bt : {alu[31:1], 1'b0};
        if (hold_v) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, hold_pc);
            chk("hold_instr", if_instr, hold_instr);
        end
        if (redir) chk("req_masked", {31'd0, req}, 32'd0);
        if (if_valid) chk("pc_plus4", if_pc4, if_pc + 32'd4);
        if (if_valid && !stall && !redir) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr actual=%h required=none",
                         if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("order_pc", if_pc, e);
                chk("instr", if_instr, memw(e));
            end
        end
        hold_v     = if_valid && stall && !redir;
        hold_pc    = if_pc;
        hold_instr = if_instr;
        if (req && ready) begin
            chk("fetch_addr", addr, nxt_pc);
            chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
            exp_q.push_back(addr);
            nxt_pc = addr + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            nxt_pc = tgt;
        end
    endtask

    task automatic pre();
        rvalid = mem_busy && (mem_cnt == 0);
        rdata  = memw(mem_addr);
        #3;
        s_acc  = req && ready;
        s_rv   = rvalid;
        s_addr = addr;
        model_check();
    endtask

    task automatic post();
        @(posedge clk);
        #1;
        if (s_rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (s_acc) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_cnt  = lat - 1;
        end
    endtask

    task automatic cyc();
        pre();
        post();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pc_sel   = 2'b00;
        alu      = 32'd0;
        bt       = 32'd0;
        stall    = 1'b0;
        ready    = 1'b1;
        lat      = 1;
        rvalid   = 1'b0;
        mem_busy = 1'b0;
        mem_addr = 32'd0;
        mem_cnt  = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          stall;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    initial begin
        vec_t tv[10];
        tv[0] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
        tv[1] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
        tv[2] = '{1'b1, 1'b1, 32'h104, 1'b1, 32'h100};
        tv[3] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100};
        tv[4] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100};
        tv[5] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100};
        tv[6] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100};
        tv[7] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h104};
        tv[8] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
        tv[9] = '{1'b0, 1'b1, 32'h10c, 1'b1, 32'h108};

        // sequential fetch and stall/skid behaviour
        do_reset();
        for (int i = 0; i < 10; i++) begin
            stall = tv[i].stall;
            pre();
            chk($sformatf("tv%0d_req", i), {31'd0, req},
                {31'd0, tv[i].req});
            if (tv[i].req) chk($sformatf("tv%0d_addr", i), addr, tv[i].addr);
            chk($sformatf("tv%0d_valid", i), {31'd0, if_valid},
                {31'd0, tv[i].valid});
            if (tv[i].valid) begin
                chk($sformatf("tv%0d_pc", i), if_pc, tv[i].pc);
                chk($sformatf("tv%0d_pc4", i), if_pc4, tv[i].pc + 32'd4);
                chk($sformatf("tv%0d_instr", i), if_instr, memw(tv[i].pc));
            end
            post();
        end

        // branch redirect while waiting, response arrives later
        do_reset();
        lat = 3;
        cyc();
        pc_sel = 2'b11;
        bt     = 32'h200;
        pre();
        chk("t3_req_masked", {31'd0, req}, 32'd0);
        post();
        pc_sel = 2'b00;
        lat    = 1;
        pre(); chk("t3_valid_a", {31'd0, if_valid}, 32'd0); post();
        pre(); chk("t3_valid_b", {31'd0, if_valid}, 32'd0); post();
        pre();
        chk("t3_valid_c", {31'd0, if_valid}, 32'd0);
        chk("t3_req", {31'd0, req}, 32'd1);
        chk("t3_addr", addr, 32'h200);
        post();
        cyc();
        pre();
        chk("t3_pc", if_pc, 32'h200);
        post();

        // jump with response in the same cycle
        do_reset();
        cyc();
        pc_sel = 2'b01;
        alu    = 32'h0000_0305;
        pre();
        chk("t4_rvalid_seen", {31'd0, rvalid}, 32'd1);
        post();
        pc_sel = 2'b10;
        pre();
        chk("t4_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_addr", addr, 32'h304);
        post();
        pc_sel = 2'b00;
        pre(); chk("t4_valid_b", {31'd0, if_valid}, 32'd0); post();
        pre();
        chk("t4_pc", if_pc, 32'h304);
        chk("t4_next_addr", addr, 32'h308);
        post();

        // PC wrap at the top of the address space
        do_reset();
        pc_sel = 2'b11;
        bt     = 32'hFFFF_FFFC;
        pre(); chk("t5_req_masked", {31'd0, req}, 32'd0); post();
        pc_sel = 2'b00;
        pre(); chk("t5_addr_top", addr, 32'hFFFF_FFFC); post();
        cyc();
        pre();
        chk("t5_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_pc4", if_pc4, 32'h0);
        chk("t5_addr_wrap", addr, 32'h0);
        post();

        // asynchronous reset during an outstanding fetch
        do_reset();
        cyc();
        cyc();
        stall = 1'b1;
        lat   = 3;
        cyc();
        pre();
        #1;
        rst = 1'b1;
        #1;
        chk("t6_valid_clr", {31'd0, if_valid}, 32'd0);
        chk("t6_pc_clr", if_pc, 32'd0);
        chk("t6_instr_clr", if_instr, 32'd0);
        chk("t6_req_clr", {31'd0, req}, 32'd0);
        model_reset();
        post();
        pre(); chk("t6_req_in_rst", {31'd0, req}, 32'd0); post();
        rst   = 1'b0;
        stall = 1'b0;
        ready = 1'b0;
        lat   = 1;
        pre();
        chk("t6_stale_rvalid", {31'd0, rvalid}, 32'd1);
        chk("t6_restart_req", {31'd0, req}, 32'd1);
        chk("t6_restart_addr", addr, RA);
        post();
        ready = 1'b1;
        pre(); chk("t6_stale_drop", {31'd0, if_valid}, 32'd0); post();
        pre(); chk("t6_wait_valid", {31'd0, if_valid}, 32'd0); post();
        pre();
        chk("t6_valid", {31'd0, if_valid}, 32'd1);
        chk("t6_pc", if_pc, RA);
        post();

        // random traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            r      = int'($urandom % 10);
            stall  = ($urandom % 4) == 0;
            pc_sel = (r == 0) ? 2'b01 :
                     (r == 1) ? 2'b11 : {1'($urandom % 2), 1'b0};
            alu    = $urandom;
            bt     = $urandom;
            ready  = ($urandom % 4) != 0;
            lat    = 1 + int'($urandom % 3);
            cyc();
        end
        stall  = 1'b0;
        pc_sel = 2'b00;
        ready  = 1'b0;
        for (int n = 0; n < 10; n++) cyc();
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly downstream of the branch-control block.
- Consumes the 2-bit next-PC select and the two redirect targets, and owns the PC register.
- Issues one-outstanding-request fetches to instruction memory through a req/ready + rvalid handshake.
- Presents fetched instructions to decode through an IF/ID register backed by a one-entry skid buffer, honouring decode stall and flushing on redirect.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_pc_sel  in  2  next-PC select from branch control: 00/10 sequential, 01 jump, 11 taken branch.
i_alu_result  in  32  jump target (jal/jalr) from ALU.
i_branch_target  in  32  PC+imm branch target.
i_stall  in  1  decode cannot accept; hold IF/ID.
o_imem_req  out  1  fetch request valid.
o_imem_addr  out  32  fetch address (= PC).
i_imem_ready  in  1  memory accepts request this cycle.
i_imem_rvalid  in  1  read data valid (>=1 cycle after acceptance).
i_imem_rdata  in  32  instruction word.
o_if_valid  out  1  IF/ID holds a valid instruction.
o_if_pc  out  32  PC of the IF/ID instruction.
o_if_pc_plus4  out  32  o_if_pc + 4, mod 2^32.
o_if_instr  out  32  instruction word.

Behaviour:
- Reset (async, any cycle, including mid-transaction):
  - pc = RESET_ADDR; state = FETCH.
  - IF/ID valid/pc/instr = 0; skid valid = 0.
  - o_imem_req = 0 while i_rst high; first request in the first cycle after deassertion.
- Redirect definition: redirect = i_pc_sel[0].
  - 01 -> target = {i_alu_result[31:1],1'b0}.
  - 11 -> target = i_branch_target.
  - 00/10 -> no redirect.
  - No alignment check in this block.
- State FETCH:
  - o_imem_req = ~redirect & ~skid_valid; o_imem_addr = pc.
  - Accept = req & i_imem_ready -> pc <= pc+4 (wraps 0xFFFF_FFFC -> 0), go WAIT.
- State WAIT:
  - o_imem_req = 0.
  - On i_imem_rvalid: deliver word (see buffering) tagged with the PC of the accepted request, go FETCH.
- State DROP:
  - o_imem_req = 0.
  - On i_imem_rvalid: discard the data, go FETCH.
- Redirect actions, same edge; redirect beats stall and any rvalid:
  - pc <= target.
  - IF/ID valid <= 0; skid valid <= 0.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid -> data discarded, go FETCH.
  - DROP stays DROP unless rvalid arrives that cycle.
  - FETCH stays FETCH; no request was issued, since req is masked.
- Buffering, non-redirect cycles:
  - consume = o_if_valid & ~i_stall.
  - If ~o_if_valid or consume, IF/ID loads the skid entry if the skid is valid. Otherwise it loads the delivered response if one arrives; otherwise IF/ID valid <= 0.
  - A delivered response not loaded into IF/ID goes into the skid.
  - The skid is never overwritten. This holds by construction: no request is issued while the skid is valid.
- Stall holds o_if_valid/pc/instr stable.
- Latency: request accepted in cycle N, rvalid in cycle M -> o_if_valid=1 from M+1, if IF/ID was free.
- Sustained throughput with ready=1 and rvalid one cycle after acceptance: one instruction per 2 cycles (one outstanding request).
- o_if_pc_plus4 is combinational from o_if_pc.

Test Plan:
1. Reset with RESET_ADDR=32'h100, ready=1, rvalid one cycle after acceptance, i_stall=0, i_pc_sel=00 -> o_imem_addr sequence 100,104,108; o_if_pc 100 with o_if_pc_plus4 104; o_if_instr matches the memory model.
2. Stall: i_stall=1 for 4 cycles while two fetches complete -> the first stays in IF/ID, the second sits in the skid, and no third request is issued. Release -> instructions at 0x100 then 0x104 in order, no loss or duplication.
3. Redirect while WAIT: i_pc_sel=11, i_branch_target=32'h200, rvalid arrives 2 cycles later -> that word is discarded; o_if_valid=0 the next cycle; next request addr 0x200.
4. Jump with rvalid in the same cycle: i_pc_sel=01, i_alu_result=32'h0000_0305 -> data dropped; next addr 0x304; i_pc_sel=10 in the following cycle is treated as sequential.
5. Wrap: pc=32'hFFFF_FFFC -> next request addr 0x0; o_if_pc_plus4 = 0x0 for that instruction.
6. Assert i_rst asynchronously during WAIT, then drop rvalid -> outputs clear immediately; fetching restarts at RESET_ADDR; the stale rvalid arriving after reset is ignored.
